// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Access size encoding, identical to the control unit's memword field.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    // Side that wins the first tie after reset in round-robin mode.
    localparam side_e RR_RESET_SIDE = SIDE_D;

    // Number of bytes moved by an access of the given size.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/arb_timeout_timer.sv
// Saturating busy-cycle counter; expire flags the last cycle a transaction may
// wait for its acknowledge. TIMEOUT = 0 disables expiry entirely.
module arb_timeout_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt;

    // Count busy cycles, holding at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            assign expire = (cnt == CW'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data
// access, one outstanding request per side, with timeout abort.
//
// state  | meaning
// IDLE   | no transaction in flight; picks a winner among eligible requests
// BUSY_I | fetch in flight; waiting for m_ack or timeout
// BUSY_D | data access in flight; waiting for m_ack or timeout
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int PRIO_DATA = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    output logic [1:0]    m_size,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata
);

    arb_state_e    state_q, state_d;
    side_e         rr_q, rr_d;
    logic          m_req_d, m_we_d;
    logic [AW-1:0] m_addr_d;
    logic [DW-1:0] m_wdata_d, i_rdata_d, d_rdata_d;
    logic [1:0]    m_size_d;
    logic          i_gnt_d, d_gnt_d, i_rvalid_d, d_rvalid_d, i_err_d, d_err_d;
    logic          tmr_clr, tmr_en, tmr_expire;
    logic          i_elig, d_elig, pick_d;

    // A side completing this cycle is masked so it is not granted again on a stale req.
    assign i_elig = i_req && !i_rvalid;
    assign d_elig = d_req && !d_rvalid;
    assign pick_d = d_elig && (!i_elig || (PRIO_DATA != 0) || (rr_q == SIDE_D));

    arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // Next-state and next-output logic; unspecified outputs hold, strobes default low.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        m_req_d    = m_req;
        m_addr_d   = m_addr;
        m_we_d     = m_we;
        m_wdata_d  = m_wdata;
        m_size_d   = m_size;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata;
        d_rdata_d  = d_rdata;
        i_err_d    = i_err;
        d_err_d    = d_err;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_elig || d_elig) begin
                    tmr_clr = 1'b1;
                    m_req_d = 1'b1;
                    if (pick_d) begin
                        state_d   = BUSY_D;
                        m_addr_d  = d_addr;
                        m_we_d    = d_we;
                        m_wdata_d = d_wdata;
                        m_size_d  = d_size;
                        d_gnt_d   = 1'b1;
                    end else begin
                        state_d   = BUSY_I;
                        m_addr_d  = i_addr;
                        m_we_d    = 1'b0;
                        m_wdata_d = '0;
                        m_size_d  = SZ_D;
                        i_gnt_d   = 1'b1;
                    end
                    if (i_elig && d_elig && (PRIO_DATA == 0)) begin
                        if (pick_d) rr_d = SIDE_I;
                        else        rr_d = SIDE_D;
                    end
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    i_rvalid_d = 1'b1;
                    i_err_d    = 1'b0;
                    i_rdata_d  = m_rdata;
                end else if (tmr_expire) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    i_rvalid_d = 1'b1;
                    i_err_d    = 1'b1;
                    i_rdata_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_err_d    = 1'b0;
                    d_rdata_d  = m_we ? '0 : m_rdata;
                end else if (tmr_expire) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_err_d    = 1'b1;
                    d_rdata_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State, pointer and all outputs are registered; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= RR_RESET_SIDE;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_we     <= 1'b0;
            m_wdata  <= '0;
            m_size   <= '0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            m_req    <= m_req_d;
            m_addr   <= m_addr_d;
            m_we     <= m_we_d;
            m_wdata  <= m_wdata_d;
            m_size   <= m_size_d;
            i_gnt    <= i_gnt_d;
            d_gnt    <= d_gnt_d;
            i_rvalid <= i_rvalid_d;
            d_rvalid <= d_rvalid_d;
            i_rdata  <= i_rdata_d;
            d_rdata  <= d_rdata_d;
            i_err    <= i_err_d;
            d_err    <= d_err_d;
        end
    end

endmodule
